player_sprite_fetch: RTL and testbench



---
 rtl/player_sprite_pkg.sv | 34 +++
 rtl/player_sprite_fetch_if.sv | 30 +++
 rtl/walk_anim_ctr.sv | 53 +++++
 rtl/player_sprite_fetch.sv | 93 +++++++++
 tb/tb_player_sprite_fetch.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_sprite_pkg.sv
// Shared types and constants for the player sprite fetch stage.
// Sprite ROM layout: six 40x64 frames packed back to back.
package player_sprite_pkg;

    typedef enum logic [1:0] {
        DIR_FRONT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_BACK  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int FRAME_SIZE = 2560;
    localparam int WALK_STEPS = 3;

    localparam logic [15:0] FRONT_BASE = 16'd0;
    localparam logic [15:0] LEFT_BASE  = 16'd7680;
    localparam logic [15:0] BACK_BASE  = 16'd10240;
    localparam logic [15:0] RIGHT_BASE = 16'd12800;

    // ROM base of the frame shown for a facing and walk step.
    function automatic logic [15:0] sprite_base(dir_t d, logic [1:0] step);
        logic [15:0] b;
        b = FRONT_BASE;
        case (d)
            DIR_FRONT: b = FRONT_BASE + 16'(step) * 16'(FRAME_SIZE);
            DIR_LEFT:  b = LEFT_BASE;
            DIR_BACK:  b = BACK_BASE;
            DIR_RIGHT: b = RIGHT_BASE;
            default:   b = FRONT_BASE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/player_sprite_fetch_if.sv
// Scan/player inputs, sprite ROM bus and pixel outputs of the fetch stage.
// master = scan/ROM side, slave = the fetch stage.
interface player_sprite_fetch_if;
    import player_sprite_pkg::*;

    logic        frame_tick;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    dir_t        dir;
    logic        moving;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [15:0] rom_addr;
    logic [4:0]  rom_data;
    logic [4:0]  pix_idx;
    logic        pix_on;

    modport master (
        output frame_tick, player_x, player_y, dir, moving,
        output draw_x, draw_y, rom_data,
        input  rom_addr, pix_idx, pix_on
    );

    modport slave (
        input  frame_tick, player_x, player_y, dir, moving,
        input  draw_x, draw_y, rom_data,
        output rom_addr, pix_idx, pix_on
    );

endinterface

// File: rtl/walk_anim_ctr.sv
// Walk-cycle step counter, advanced only on frame ticks.
// step cycles 0->1->2 every ANIM_DIV walking ticks.
module walk_anim_ctr
    import player_sprite_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       enable,
    output logic [1:0] step
);

    localparam logic [7:0] CNT_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [1:0] STEP_LAST = 2'(WALK_STEPS - 1);

    logic [7:0] anim_cnt_q, anim_cnt_d;
    logic [1:0] step_q, step_d;

    // Advance on walking ticks, clear on idle ticks, hold otherwise.
    always_comb begin
        anim_cnt_d = anim_cnt_q;
        step_d     = step_q;
        if (frame_tick) begin
            if (enable) begin
                if (anim_cnt_q == CNT_LAST) begin
                    anim_cnt_d = 8'd0;
                    step_d     = (step_q == STEP_LAST) ? 2'd0 : step_q + 2'd1;
                end else begin
                    anim_cnt_d = anim_cnt_q + 8'd1;
                end
            end else begin
                anim_cnt_d = 8'd0;
                step_d     = 2'd0;
            end
        end
    end

    // Counter state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            anim_cnt_q <= 8'd0;
            step_q     <= 2'd0;
        end else begin
            anim_cnt_q <= anim_cnt_d;
            step_q     <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/player_sprite_fetch.sv
// Sprite ROM address generation and pixel qualification.
// Player state is frozen at frame_tick so a frame never tears.
module player_sprite_fetch
    import player_sprite_pkg::*;
#(
    parameter int         SPRITE_W        = 40,
    parameter int         SPRITE_H        = 64,
    parameter int         ANIM_DIV        = 8,
    parameter logic [4:0] TRANSPARENT_IDX = 5'd0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    player_sprite_fetch_if.slave bus
);

    logic [9:0]  px_q, px_d;
    logic [9:0]  py_q, py_d;
    dir_t        ldir_q, ldir_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic        in_box_d1_q, in_box_d1_d;
    logic        in_box_d2_q, in_box_d2_d;

    logic [1:0]  step;
    logic        walk_en;
    logic        in_box;
    logic [10:0] dx11, dy11, px11, py11;
    logic [9:0]  col, row;
    logic [15:0] offset;

    assign walk_en = (bus.dir == DIR_FRONT) && bus.moving;

    walk_anim_ctr #(
        .ANIM_DIV (ANIM_DIV)
    ) u_walk (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (bus.frame_tick),
        .enable     (walk_en),
        .step       (step)
    );

    // Box test in 11 bits so a sprite at the right/bottom edge clips, not wraps.
    always_comb begin
        dx11   = {1'b0, bus.draw_x};
        dy11   = {1'b0, bus.draw_y};
        px11   = {1'b0, px_q};
        py11   = {1'b0, py_q};
        in_box = (dx11 >= px11) && (dx11 < px11 + 11'(SPRITE_W))
              && (dy11 >= py11) && (dy11 < py11 + 11'(SPRITE_H));
        col    = bus.draw_x - px_q;
        row    = bus.draw_y - py_q;
        offset = 16'(row) * 16'(SPRITE_W) + 16'(col);
    end

    // Next state: frame latch plus the address / in_box pipeline.
    always_comb begin
        px_d        = px_q;
        py_d        = py_q;
        ldir_d      = ldir_q;
        if (bus.frame_tick) begin
            px_d   = bus.player_x;
            py_d   = bus.player_y;
            ldir_d = bus.dir;
        end
        rom_addr_d  = in_box ? sprite_base(ldir_q, step) + offset : 16'd0;
        in_box_d1_d = in_box;
        in_box_d2_d = in_box_d1_q;
    end

    // Registered state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            px_q        <= 10'd0;
            py_q        <= 10'd0;
            ldir_q      <= DIR_FRONT;
            rom_addr_q  <= 16'd0;
            in_box_d1_q <= 1'b0;
            in_box_d2_q <= 1'b0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            ldir_q      <= ldir_d;
            rom_addr_q  <= rom_addr_d;
            in_box_d1_q <= in_box_d1_d;
            in_box_d2_q <= in_box_d2_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pix_idx  = in_box_d2_q ? bus.rom_data : 5'd0;
    assign bus.pix_on   = in_box_d2_q && (bus.rom_data != TRANSPARENT_IDX);

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Bench for player_sprite_fetch: scoreboard queues filled by stimulus,
// drained by a monitor, expectations from a frame-level model.
module tb_player_sprite_fetch;
    import player_sprite_pkg::*;

    localparam int SW = 40;
    localparam int SH = 64;
    localparam int AD = 2;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    player_sprite_fetch_if bus();

    player_sprite_fetch #(
        .SPRITE_W        (SW),
        .SPRITE_H        (SH),
        .ANIM_DIV        (AD),
        .TRANSPARENT_IDX (5'd0)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM contents; every sixth word transparent.
    function automatic logic [4:0] rom_fn(int a);
        if (a % 6 == 0) return 5'd0;
        return 5'((a * 13 + a / 16) % 31 + 1);
    endfunction

    always @(posedge Clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        int         addr;
        logic [4:0] idx;
        bit         on;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    int   checks = 0;
    int   errors = 0;
    bit   hold = 1'b1;

    // Frame-level model: latched box and consecutive walking ticks.
    int   m_px, m_py, m_walk;
    dir_t m_dir;

    // Player inputs applied at the next driven cycle.
    int   np_x, np_y;
    dir_t np_dir;
    bit   np_mv;

    task automatic model_reset();
        m_px = 0; m_py = 0; m_walk = 0; m_dir = DIR_FRONT;
    endtask

    function automatic int model_base();
        case (m_dir)
            DIR_FRONT: return ((m_walk / AD) % 3) * 2560;
            DIR_LEFT:  return 7680;
            DIR_BACK:  return 10240;
            default:   return 12800;
        endcase
    endfunction

    function automatic bit model_in(int x, int y);
        return x >= m_px && x < m_px + SW && y >= m_py && y < m_py + SH;
    endfunction

    function automatic int model_addr(int x, int y);
        if (!model_in(x, y)) return 0;
        return model_base() + (y - m_py) * SW + (x - m_px);
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs now; lit >= 0 overrides the expected address.
    task automatic apply(bit tick, int x, int y, int lit);
        exp_t e;
        bus.frame_tick = tick;
        bus.draw_x     = 10'(x);
        bus.draw_y     = 10'(y);
        bus.player_x   = 10'(np_x);
        bus.player_y   = 10'(np_y);
        bus.dir        = np_dir;
        bus.moving     = np_mv;
        if (!hold) begin
            e.c    = cyc;
            e.addr = (lit >= 0) ? lit : model_addr(x, y);
            e.idx  = model_in(x, y) ? rom_fn(e.addr) : 5'd0;
            e.on   = model_in(x, y) && (e.idx != 5'd0);
            aq.push_back(e);
            pq.push_back(e);
        end
        if (tick) begin
            m_px  = np_x;
            m_py  = np_y;
            m_dir = np_dir;
            if (np_dir == DIR_FRONT && np_mv) m_walk++;
            else m_walk = 0;
        end
    endtask

    task automatic drive(bit tick, int x, int y, int lit = -1);
        @(negedge Clk);
        apply(tick, x, y, lit);
    endtask

    task automatic player(int x, int y, dir_t d, bit mv);
        np_x = x; np_y = y; np_dir = d; np_mv = mv;
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 6 && (aq.size() > 0 || pq.size() > 0); i++)
            @(negedge Clk);
        checks++;
        if (aq.size() > 0 || pq.size() > 0) begin
            errors++;
            $display("FAIL %s queues not drained got %0d expected 0", nm,
                     aq.size() + pq.size());
        end
    endtask

    // Monitor: rom_addr one edge after issue, pixel two edges after.
    initial forever begin
        @(negedge Clk);
        if (!hold) begin
            if (aq.size() > 0 && aq[0].c + 1 <= cyc) begin
                check("rom_addr", int'(bus.rom_addr), aq[0].addr);
                void'(aq.pop_front());
            end
            if (pq.size() > 0 && pq[0].c + 2 <= cyc) begin
                check("pix_idx", int'(bus.pix_idx), int'(pq[0].idx));
                check("pix_on", int'(bus.pix_on), int'(pq[0].on));
                void'(pq.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x, y;
        model_reset();
        player(0, 0, DIR_FRONT, 1'b0);
        apply(1'b0, 500, 500, -1);
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_rom_addr", int'(bus.rom_addr), 0);
        check("reset_pix_on", int'(bus.pix_on), 0);
        check("reset_pix_idx", int'(bus.pix_idx), 0);
        Reset_n = 1'b1;
        hold = 1'b0;

        // Basic latch and box corners.
        player(100, 200, DIR_FRONT, 1'b0);
        drive(1'b1, 0, 0);
        drive(1'b0, 100, 200, 0);
        drive(1'b0, 139, 263, 2559);
        drive(1'b0, 140, 263, 0);
        drive(1'b0, 139, 264, 0);
        drive(1'b0, 99, 200, 0);
        drive(1'b0, 120, 230);

        // Facing right, then a dir change without a tick.
        player(100, 200, DIR_RIGHT, 1'b0);
        drive(1'b1, 0, 0);
        drive(1'b0, 105, 202, 12885);
        player(100, 200, DIR_LEFT, 1'b0);
        drive(1'b0, 105, 202, 12885);
        drive(1'b0, 110, 210);

        // Walk animation with ANIM_DIV = 2.
        player(300, 100, DIR_FRONT, 1'b1);
        repeat (2) drive(1'b1, 0, 0);
        drive(1'b0, 300, 100, 2560);
        repeat (2) drive(1'b1, 0, 0);
        drive(1'b0, 300, 100, 5120);
        repeat (2) drive(1'b1, 0, 0);
        drive(1'b0, 300, 100, 0);
        drive(1'b1, 0, 0);
        player(300, 100, DIR_FRONT, 1'b0);
        drive(1'b1, 0, 0);
        drive(1'b0, 301, 100, 1);
        player(300, 100, DIR_FRONT, 1'b1);
        drive(1'b1, 0, 0);
        drive(1'b0, 301, 100, 1);
        drive(1'b1, 0, 0);
        drive(1'b0, 301, 100, 2561);

        // Right-edge clipping without wrap.
        player(620, 50, DIR_FRONT, 1'b0);
        drive(1'b1, 0, 0);
        drive(1'b0, 639, 50, 19);
        drive(1'b0, 0, 50, 0);
        player(1000, 1000, DIR_BACK, 1'b0);
        drive(1'b1, 0, 0);
        drive(1'b0, 1023, 1000, 10263);
        drive(1'b0, 3, 1000, 0);
        drive(1'b0, 1010, 1023);
        drive(1'b0, 1010, 2, 0);

        // Held frame_tick: every edge counts.
        player(40, 40, DIR_FRONT, 1'b1);
        repeat (3) drive(1'b1, 45, 45);
        drive(1'b0, 45, 45);

        // Randomised frames with mid-frame input churn.
        for (int f = 0; f < 40; f++) begin
            player($urandom_range(0, 1023), $urandom_range(0, 1023),
                   ($urandom_range(0, 1) == 1) ? DIR_FRONT
                       : dir_t'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0);
            drive(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0)
                drive(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 9) == 0)
                    player($urandom_range(0, 1023), $urandom_range(0, 1023),
                           dir_t'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
                x = (m_px + $urandom_range(0, 49) - 5) & 1023;
                y = (m_py + $urandom_range(0, 73) - 5) & 1023;
                drive(1'b0, x, y);
            end
        end
        drain("pre_reset");

        // Reset mid-scan while a sprite pixel is in flight.
        hold = 1'b1;
        player(200, 200, DIR_FRONT, 1'b0);
        drive(1'b1, 0, 0);
        drive(1'b0, 211, 205);
        @(negedge Clk);
        check("pre_rst_addr", int'(bus.rom_addr), 211);
        @(posedge Clk);
        #1;
        check("pre_rst_pix_on", int'(bus.pix_on), 1);
        #1;
        Reset_n = 1'b0;
        #1;
        check("rst_rom_addr", int'(bus.rom_addr), 0);
        check("rst_pix_on", int'(bus.pix_on), 0);
        check("rst_pix_idx", int'(bus.pix_idx), 0);
        drive(1'b0, 211, 205);
        drive(1'b0, 212, 206);
        @(negedge Clk);
        check("rst_hold_pix_on", int'(bus.pix_on), 0);
        Reset_n = 1'b1;
        model_reset();
        hold = 1'b0;
        apply(1'b0, 5, 3, 125);
        @(posedge Clk);
        #1;
        check("post_rst_pix_on", int'(bus.pix_on), 0);
        drive(1'b0, 6, 3);
        drive(1'b0, 39, 63, 2559);
        drive(1'b0, 40, 3, 0);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
